rr_grant_sequencer: RTL and testbench
=====================================

# rr_grant_sequencer

Round-robin arbiter that sits directly upstream of the 4-to-16 grant decoder. Picks one of 16 requesters, drives a registered 4-bit grant index plus enable into the decoder, and holds the grant until the owner releases it or a hold timeout expires. It inserts one dead cycle between grants, so the decoder's one-hot output never switches directly from one owner to another.

## Interface
- MAX_HOLD, default 64: maximum cycles a grant may be held before forced release; 0 disables the timeout.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  request vector; bit k set means requester k wants the grant.
- release_i  input  1  current owner finished; sampled only in GRANT.
- grant_idx  output  4  binary index of the current owner; feeds decoder binary_in.
- grant_en  output  1  grant valid; feeds decoder enable.
- timeout_o  output  1  one-cycle pulse when a grant is force-released.
- busy  output  1  high in GRANT or GAP.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: grant_en=1.
  - GAP: one dead cycle, grant_en=0.
- Rotating priority pointer ptr[3:0]. Winner is the first set bit of req scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod-16 wrap).
- IDLE: if req≠0, load grant_idx=winner, set grant_en, ptr←winner+1 mod 16, go to GRANT. Otherwise stay.
- GRANT ends on the first edge where any of these holds. All three go to GAP with grant_en←0.
  - release_i=1.
  - req[grant_idx]=0 (owner dropped its request).
  - Hold counter reaches MAX_HOLD-1 with MAX_HOLD≠0. This case also sets timeout_o=1 for the GAP cycle.
- Precedence when release, drop and timeout coincide: release/drop win, and timeout_o stays 0.
- GAP: same arbitration as IDLE, still using ptr. If req≠0, go to GRANT next edge; else go to IDLE.
- Owner that releases and re-requests immediately ranks last behind every other active requester (ptr already advanced past it).
- grant_idx holds its last value while grant_en=0; the downstream decoder ignores it.
- Hold counter: width $clog2(MAX_HOLD+1). Cleared on entry to GRANT, increments each GRANT cycle, saturates.
- release_i outside GRANT is ignored.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: grant_en=0, grant_idx=0, timeout_o=0, busy=0, ptr=0, counter=0, state=IDLE. Index 0 has top priority after reset.
- Reset asserted mid-grant: grant_en drops immediately (asynchronous). Arbitration restarts from ptr=0 after deassertion.
- Latency:
  - req sampled at edge n in IDLE → grant_en=1 after edge n.
  - Release sampled at edge m → grant_en=0 for exactly one cycle after edge m. The next grant, if any, is visible after edge m+1.
- Timeout: a grant is visible for exactly MAX_HOLD cycles, then GAP with timeout_o high for 1 cycle.
- Decoder output for a grant = one-hot of grant_idx during grant_en cycles; all-zero otherwise.

## Structure
- Package rr_grant_pkg:
  - NUM_REQ=16, IDX_W=4.
  - typedef enum logic [1:0] {IDLE, GRANT, GAP} rr_state_t.
  - typedef logic [IDX_W-1:0] grant_idx_t.
- Sub-module rr_pick (combinational): inputs req and ptr; outputs winner index and any_req. Implemented as rotate, priority-encode, un-rotate.
- Top module holds the FSM, ptr, hold counter and output registers.

## Test plan
- Reset then req=16'h0001 → grant_idx=0, grant_en=1 after one edge; ptr=1. Assert release_i → one GAP cycle with grant_en=0, then IDLE; busy=0.
- req=16'h8001 constant, release_i pulsed once per grant → grant order 0, 15, 0, 15…, with exactly one grant_en=0 cycle between grants.
- Wrap: force ptr=15 via prior grant to 14, req=16'h4001 → next grant index 0, then 14.
- MAX_HOLD=4, req=16'h0010, never release → grant_en high exactly 4 cycles at idx 4, then timeout_o=1 for one cycle, then re-grant idx 4.
- Release and timeout on the same edge (MAX_HOLD=4, release on 4th cycle) → GAP with timeout_o=0. Owner drops req[3] mid-grant → GAP next edge, no timeout.
- rst_n asserted while granted to idx 9 → grant_en=0 immediately. After release, req=16'h0600 → grant idx 9 (ptr back to 0).

Source files
------------

// File: rtl/rr_grant_pkg.sv
// Shared types and constants for the round-robin grant sequencer.
// Sized for 16 requesters feeding a 4-to-16 grant decoder.
package rr_grant_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } rr_state_t;

    typedef logic [IDX_W-1:0] grant_idx_t;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic grant_idx_t first_set(input logic [NUM_REQ-1:0] vec);
        grant_idx_t pos;
        pos = {IDX_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = vec[i] ? IDX_W'(i) : pos;
        end
        return pos;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate the request vector so ptr lands at
// bit 0, take the first set bit, then add ptr back to get the absolute index.
module rr_pick
    import rr_grant_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot_s;
    logic [IDX_W-1:0]   off_s;

    // Rotate, priority-encode, un-rotate (the 4-bit add wraps mod 16).
    always_comb begin
        rot_s   = NUM_REQ'({req, req} >> ptr);
        off_s   = first_set(rot_s);
        winner  = ptr + off_s;
        any_req = |req;
    end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter driving a registered grant index/enable into the grant
// decoder, with owner release, hold timeout and one dead cycle between grants.
module rr_grant_sequencer
    import rr_grant_pkg::*;
#(
    parameter int MAX_HOLD = 64
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_i,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_en,
    output logic               timeout_o,
    output logic               busy
);

    localparam bit                   HOLD_EN   = (MAX_HOLD > 32'sd0);
    localparam int                   CNT_W     = HOLD_EN ? $clog2(MAX_HOLD + 32'sd1) : 1;
    localparam logic [CNT_W-1:0]     HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 32'sd1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1'b1);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1'b1);

    rr_state_t        state_r;
    logic [IDX_W-1:0] ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] winner_s;
    logic             any_s;
    logic             owner_done_s;
    logic             hold_expired_s;

    rr_pick u_pick (
        .req     (req),
        .ptr     (ptr_r),
        .winner  (winner_s),
        .any_req (any_s)
    );

    // Grant end conditions; release/drop take precedence over the timeout.
    always_comb begin
        owner_done_s   = release_i | ~req[grant_idx];
        hold_expired_s = HOLD_EN && (cnt_r == HOLD_LAST);
    end

    // Arbitration FSM with pointer, hold counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= {IDX_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            grant_idx <= {IDX_W{1'b0}};
            grant_en  <= 1'b0;
            timeout_o <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, GAP: begin
                    timeout_o <= 1'b0;
                    if (any_s) begin
                        state_r   <= GRANT;
                        grant_idx <= winner_s;
                        grant_en  <= 1'b1;
                        busy      <= 1'b1;
                        ptr_r     <= winner_s + IDX_ONE;
                        cnt_r     <= {CNT_W{1'b0}};
                    end else begin
                        state_r  <= IDLE;
                        grant_en <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                GRANT: begin
                    if (owner_done_s || hold_expired_s) begin
                        state_r   <= GAP;
                        grant_en  <= 1'b0;
                        busy      <= 1'b1;
                        timeout_o <= ~owner_done_s;
                    end else begin
                        timeout_o <= 1'b0;
                        if (cnt_r != CNT_MAX) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    grant_en  <= 1'b0;
                    timeout_o <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Self-checking bench: directed vector table, reset-mid-grant sequence, and
// randomized traffic compared against a behavioural round-robin model.
module tb_rr_grant_sequencer;

    localparam int MH = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        release_i;
    logic [3:0]  grant_idx;
    logic        grant_en;
    logic        timeout_o;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    rr_grant_sequencer #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .grant_idx (grant_idx),
        .grant_en  (grant_en),
        .timeout_o (timeout_o),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        rel;
        logic        en;
        logic [3:0]  idx;
        logic        to;
        logic        busy;
    } vec_t;

    vec_t tbl [32];

    // Reference model: mode 0 idle, 1 granted, 2 dead cycle.
    int         m_mode;
    int         m_ptr;
    int         m_held;
    logic       m_en;
    logic       m_to;
    logic       m_busy;
    logic [3:0] m_idx;

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_held = 0;
        m_en = 1'b0; m_to = 1'b0; m_busy = 1'b0; m_idx = 4'd0;
    endtask

    task automatic model_edge(input logic [15:0] r, input logic rl);
        int  win;
        logic fin;
        logic tmo;
        win = -1;
        for (int k = 0; k < 16; k++) begin
            if (win < 0 && r[(m_ptr + k) % 16]) win = (m_ptr + k) % 16;
        end
        if (m_mode == 1) begin
            fin = rl || !r[m_idx];
            tmo = (MH != 0) && (m_held == MH);
            if (fin || tmo) begin
                m_mode = 2; m_en = 1'b0; m_to = !fin; m_busy = 1'b1;
            end else begin
                m_held++; m_to = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            if (win >= 0) begin
                m_mode = 1; m_idx = 4'(win); m_en = 1'b1; m_busy = 1'b1;
                m_ptr = (win + 1) % 16; m_held = 1;
            end else begin
                m_mode = 0; m_en = 1'b0; m_busy = 1'b0;
            end
        end
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input logic e_en, input logic [3:0] e_idx,
                           input logic e_to, input logic e_busy);
        check({tag, ".grant_en"},  16'(grant_en),  16'(e_en));
        check({tag, ".grant_idx"}, 16'(grant_idx), 16'(e_idx));
        check({tag, ".timeout_o"}, 16'(timeout_o), 16'(e_to));
        check({tag, ".busy"},      16'(busy),      16'(e_busy));
    endtask

    // Drive at negedge, clock once, advance model, return at next negedge.
    task automatic step(input logic [15:0] r, input logic rl);
        req = r;
        release_i = rl;
        @(posedge clk);
        model_edge(r, rl);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        cmp_out(tag, 1'b0, 4'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] cur_req;
    logic        rl;

    initial begin
        // {req, release, en, idx, timeout, busy} after the clock edge
        tbl[0]  = '{16'h0001, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1};
        tbl[1]  = '{16'h0001, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        tbl[2]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        tbl[3]  = '{16'h8001, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1};
        tbl[4]  = '{16'h8001, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1};
        tbl[5]  = '{16'h8001, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1};
        tbl[6]  = '{16'h8001, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        tbl[7]  = '{16'h8001, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1};
        tbl[8]  = '{16'h8001, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1};
        tbl[9]  = '{16'h0000, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0};
        tbl[10] = '{16'h4000, 1'b0, 1'b1, 4'd14, 1'b0, 1'b1};
        tbl[11] = '{16'h4001, 1'b1, 1'b0, 4'd14, 1'b0, 1'b1};
        tbl[12] = '{16'h4001, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1};
        tbl[13] = '{16'h4001, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
        tbl[14] = '{16'h4001, 1'b0, 1'b1, 4'd14, 1'b0, 1'b1};
        tbl[15] = '{16'h0000, 1'b0, 1'b0, 4'd14, 1'b0, 1'b1};
        tbl[16] = '{16'h0000, 1'b0, 1'b0, 4'd14, 1'b0, 1'b0};
        tbl[17] = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[18] = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[19] = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[20] = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[21] = '{16'h0010, 1'b0, 1'b0, 4'd4,  1'b1, 1'b1};
        tbl[22] = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[23] = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[24] = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[25] = '{16'h0010, 1'b0, 1'b1, 4'd4,  1'b0, 1'b1};
        tbl[26] = '{16'h0010, 1'b1, 1'b0, 4'd4,  1'b0, 1'b1};
        tbl[27] = '{16'h0000, 1'b0, 1'b0, 4'd4,  1'b0, 1'b0};
        tbl[28] = '{16'h0008, 1'b0, 1'b1, 4'd3,  1'b0, 1'b1};
        tbl[29] = '{16'h0008, 1'b0, 1'b1, 4'd3,  1'b0, 1'b1};
        tbl[30] = '{16'h0000, 1'b0, 1'b0, 4'd3,  1'b0, 1'b1};
        tbl[31] = '{16'h0000, 1'b0, 1'b0, 4'd3,  1'b0, 1'b0};

        rst_n = 1'b0;
        req = 16'h0000;
        release_i = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset("reset");

        for (int i = 0; i < 32; i++) begin
            step(tbl[i].req, tbl[i].rel);
            cmp_out($sformatf("tbl%0d", i), tbl[i].en, tbl[i].idx, tbl[i].to, tbl[i].busy);
        end

        // Reset while granted to 9: enable drops at once, pointer returns to 0.
        step(16'h0200, 1'b0);
        cmp_out("grant9", 1'b1, 4'd9, 1'b0, 1'b1);
        do_reset("rst_mid_grant");
        step(16'h0600, 1'b0);
        cmp_out("after_rst", 1'b1, 4'd9, 1'b0, 1'b1);
        step(16'h0600, 1'b1);
        cmp_out("after_rst_gap", 1'b0, 4'd9, 1'b0, 1'b1);
        step(16'h0600, 1'b0);
        cmp_out("after_rst_next", 1'b1, 4'd10, 1'b0, 1'b1);

        cur_req = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       cur_req = 16'h0000;
                    1:       cur_req = 16'(32'd1 << $urandom_range(0, 15));
                    2:       cur_req = 16'($urandom) & 16'($urandom);
                    default: cur_req = 16'($urandom);
                endcase
            end
            rl = ($urandom_range(0, 7) == 0);
            if (c == 1500) do_reset("rnd_reset");
            step(cur_req, rl);
            cmp_out($sformatf("rnd%0d", c), m_en, m_idx, m_to, m_busy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
